seq_mult: RTL and testbench

SEQ_MULT -- requirements
Module: seq_mult

---
 rtl/seq_mult_pkg.sv | 13 +
 rtl/mult_add_stage.sv | 14 +
 rtl/seq_mult.sv | 145 ++++++++++++++
 tb/tb_seq_mult.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding
// and the default operand width.
package seq_mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mult_add_stage.sv
// One (WIDTH+1)-bit add used by each shift-add iteration; the carry becomes
// the top bit shifted into the accumulator.
module mult_add_stage #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/seq_mult.sv
// Radix-2 sequential multiplier: operands are converted to sign/magnitude on
// accept, WIDTH shift-add steps run in BUSY, the signed product is held in DONE.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [WIDTH-1:0]     MULTIPLICAND,
    input  logic [WIDTH-1:0]     MULTIPLIER,
    input  logic                 SIGNED,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [2*WIDTH-1:0]   PRODUCT,
    output logic [WIDTH-1:0]     OUT,
    output logic                 OVERFLOW,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [2*WIDTH-1:0] PROD_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_mag_q, a_mag_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mpl_q, mpl_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic                 signed_q, signed_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH-1:0]     a_abs_s, b_abs_s, add_b_s, sum_s;
    logic                 carry_s;
    logic [WIDTH-1:0]     acc_next_s, mpl_next_s;
    logic [2*WIDTH-1:0]   mag_s, prod_s;
    logic [WIDTH:0]       hi_s;
    logic                 ovf_s;

    // Magnitudes stay WIDTH bits unsigned so -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
    assign a_abs_s = (SIGNED && MULTIPLICAND[WIDTH-1]) ? (~MULTIPLICAND + W_ONE) : MULTIPLICAND;
    assign b_abs_s = (SIGNED && MULTIPLIER[WIDTH-1])   ? (~MULTIPLIER + W_ONE)   : MULTIPLIER;
    assign add_b_s = mpl_q[0] ? a_mag_q : W_ZERO;

    mult_add_stage #(.WIDTH(WIDTH)) u_add (
        .a_i     (acc_q),
        .b_i     (add_b_s),
        .sum_o   (sum_s),
        .carry_o (carry_s)
    );

    assign acc_next_s = {carry_s, sum_s[WIDTH-1:1]};
    assign mpl_next_s = {sum_s[0], mpl_q[WIDTH-1:1]};
    assign mag_s      = {acc_next_s, mpl_next_s};
    assign prod_s     = sign_q ? (~mag_s + PROD_ONE) : mag_s;
    assign hi_s       = prod_s[2*WIDTH-1:WIDTH-1];
    assign ovf_s      = signed_q ? ((|hi_s) & ~(&hi_s)) : (|prod_s[2*WIDTH-1:WIDTH]);

    // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d   = state_q;
        a_mag_d   = a_mag_q;
        acc_d     = acc_q;
        mpl_d     = mpl_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        signed_d  = signed_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    a_mag_d  = a_abs_s;
                    mpl_d    = b_abs_s;
                    acc_d    = W_ZERO;
                    cnt_d    = {CW{1'b0}};
                    sign_d   = SIGNED & (MULTIPLICAND[WIDTH-1] ^ MULTIPLIER[WIDTH-1]);
                    signed_d = SIGNED;
                    state_d  = ST_BUSY;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                acc_d = acc_next_s;
                mpl_d = mpl_next_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    product_d = prod_s;
                    ovf_d     = ovf_s;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (OUT_READY) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            a_mag_q   <= W_ZERO;
            acc_q     <= W_ZERO;
            mpl_q     <= W_ZERO;
            cnt_q     <= {CW{1'b0}};
            sign_q    <= 1'b0;
            signed_q  <= 1'b0;
            product_q <= {(2*WIDTH){1'b0}};
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_mag_q   <= a_mag_d;
            acc_q     <= acc_d;
            mpl_q     <= mpl_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            signed_q  <= signed_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    assign IN_READY  = (state_q == ST_IDLE);
    assign OUT_VALID = (state_q == ST_DONE);
    assign PRODUCT   = product_q;
    assign OUT       = product_q[WIDTH-1:0];
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed plus randomized checks of seq_mult at WIDTH=8 and WIDTH=16 against
// an integer-arithmetic reference model.
module tb_seq_mult;

    logic        CLK;
    logic        RESET;

    logic [7:0]  mc8, mr8, out8;
    logic        sg8, iv8, ir8, ovf8, ov8, or8;
    logic [15:0] prod8;

    logic [15:0] mc16, mr16, out16;
    logic        sg16, iv16, ir16, ovf16, ov16, or16;
    logic [31:0] prod16;

    int n_checks = 0;
    int n_errors = 0;

    seq_mult #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RESET(RESET), .MULTIPLICAND(mc8), .MULTIPLIER(mr8),
        .SIGNED(sg8), .IN_VALID(iv8), .IN_READY(ir8), .PRODUCT(prod8),
        .OUT(out8), .OVERFLOW(ovf8), .OUT_VALID(ov8), .OUT_READY(or8)
    );

    seq_mult #(.WIDTH(16)) dut16 (
        .CLK(CLK), .RESET(RESET), .MULTIPLICAND(mc16), .MULTIPLIER(mr16),
        .SIGNED(sg16), .IN_VALID(iv16), .IN_READY(ir16), .PRODUCT(prod16),
        .OUT(out16), .OVERFLOW(ovf16), .OUT_VALID(ov16), .OUT_READY(or16)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Signed or unsigned integer product, truncated to 2w bits, and the range test.
    function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                      input logic s, output logic [63:0] prod, output logic ovf);
        longint m, av, bv, p;
        m  = longint'(1) <<< w;
        av = longint'(a);
        bv = longint'(b);
        if (s && av >= m / 2) av = av - m;
        if (s && bv >= m / 2) bv = bv - m;
        p    = av * bv;
        prod = 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
        if (s) ovf = (p < -(m / 2)) || (p >= m / 2);
        else   ovf = (p >= m);
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input int stall, input bit scramble, input string tag);
        logic [63:0] ep;
        logic        eo;
        int          lat;
        bit          done;
        logic [15:0] held;
        ref_model(8, {24'd0, a}, {24'd0, b}, s, ep, eo);
        @(negedge CLK);
        check({tag, "_ready"}, {63'd0, ir8}, 64'd1);
        mc8 = a; mr8 = b; sg8 = s; iv8 = 1'b1;
        @(posedge CLK);
        #1;
        iv8 = 1'b0;
        lat = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (scramble) begin
                mc8 = 8'($urandom); mr8 = 8'($urandom);
                sg8 = 1'($urandom); iv8 = 1'($urandom);
            end
            @(posedge CLK);
            #1;
            lat++;
            if (ov8) done = 1'b1;
        end
        iv8 = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'd8);
        check({tag, "_product"}, {48'd0, prod8}, ep);
        check({tag, "_out"}, {56'd0, out8}, {56'd0, ep[7:0]});
        check({tag, "_ovf"}, {63'd0, ovf8}, {63'd0, eo});
        check({tag, "_busy_ready"}, {63'd0, ir8}, 64'd0);
        held = prod8;
        for (int i = 0; i < stall; i++) begin
            iv8 = 1'b1; mc8 = 8'($urandom); mr8 = 8'($urandom);
            @(posedge CLK);
            #1;
            check({tag, "_stall_prod"}, {48'd0, prod8}, {48'd0, held});
            check({tag, "_stall_ready"}, {63'd0, ir8}, 64'd0);
            check({tag, "_stall_valid"}, {63'd0, ov8}, 64'd1);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge CLK);
        #1;
        or8 = 1'b0;
        check({tag, "_release_valid"}, {63'd0, ov8}, 64'd0);
        check({tag, "_release_ready"}, {63'd0, ir8}, 64'd1);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s, input string tag);
        logic [63:0] ep;
        logic        eo;
        int          lat;
        bit          done;
        ref_model(16, {16'd0, a}, {16'd0, b}, s, ep, eo);
        @(negedge CLK);
        mc16 = a; mr16 = b; sg16 = s; iv16 = 1'b1;
        @(posedge CLK);
        #1;
        iv16 = 1'b0;
        lat = 0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge CLK);
            #1;
            lat++;
            if (ov16) done = 1'b1;
        end
        check({tag, "_latency"}, 64'(lat), 64'd16);
        check({tag, "_product"}, {32'd0, prod16}, ep);
        check({tag, "_out"}, {48'd0, out16}, {48'd0, ep[15:0]});
        check({tag, "_ovf"}, {63'd0, ovf16}, {63'd0, eo});
        or16 = 1'b1;
        @(posedge CLK);
        #1;
        or16 = 1'b0;
        check({tag, "_release_ready"}, {63'd0, ir16}, 64'd1);
    endtask

    initial begin
        int vhigh;
        RESET = 1'b0;
        mc8 = 8'd0; mr8 = 8'd0; sg8 = 1'b0; iv8 = 1'b0; or8 = 1'b0;
        mc16 = 16'd0; mr16 = 16'd0; sg16 = 1'b0; iv16 = 1'b0; or16 = 1'b0;

        #3;
        check("rst_in_ready", {63'd0, ir8}, 64'd1);
        check("rst_out_valid", {63'd0, ov8}, 64'd0);
        check("rst_product", {48'd0, prod8}, 64'd0);
        check("rst_out", {56'd0, out8}, 64'd0);
        check("rst_ovf", {63'd0, ovf8}, 64'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // Directed corner cases.
        run8(8'd255, 8'd255, 1'b0, 0, 1'b0, "u255x255");
        run8(8'hFD, 8'd5, 1'b1, 0, 1'b0, "s_m3x5");
        run8(8'h80, 8'h80, 1'b1, 0, 1'b0, "s_m128xm128");
        run8(8'h80, 8'h7F, 1'b1, 0, 1'b0, "s_m128x127");
        run8(8'd0, 8'd200, 1'b0, 0, 1'b0, "u0x200");
        run8(8'd37, 8'd91, 1'b0, 5, 1'b0, "stall");

        // Reset in the middle of 12 x 12 must clear outputs without a clock edge.
        @(negedge CLK);
        mc8 = 8'd12; mr8 = 8'd12; sg8 = 1'b0; iv8 = 1'b1;
        @(posedge CLK);
        #1;
        iv8 = 1'b0;
        repeat (4) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("abort_product", {48'd0, prod8}, 64'd0);
        check("abort_out", {56'd0, out8}, 64'd0);
        check("abort_ovf", {63'd0, ovf8}, 64'd0);
        check("abort_in_ready", {63'd0, ir8}, 64'd1);
        check("abort_out_valid", {63'd0, ov8}, 64'd0);
        @(negedge CLK);
        RESET = 1'b1;
        vhigh = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (ov8) vhigh++;
        end
        check("abort_no_residue", 64'(vhigh), 64'd0);
        run8(8'd7, 8'd6, 1'b0, 0, 1'b0, "after_abort_7x6");

        // Random operands, changing the inputs every cycle while busy.
        for (int i = 0; i < 20; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b1, "rand8");
        end

        run16(16'hFFFF, 16'h0002, 1'b0, "u16_ffffx2");
        run16(16'h8000, 16'h8000, 1'b1, "s16_min_sq");
        for (int i = 0; i < 6; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), "rand16");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
